width_funnel_buffer: RTL and testbench

// - Buffered width-conversion funnel: input FIFO (Buffering words of IWidth), then an

---
 rtl/width_funnel_buffer_if.sv | 24 ++
 rtl/width_funnel_buffer.sv | 178 +++++++++++++++++
 tb/tb_width_funnel_buffer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/width_funnel_buffer_if.sv
// ---------------------------------------------------------------------------
// width_funnel_buffer_if
// Handshake bundle for width_funnel_buffer.
//   in_valid / in_accept / in_data    : IWidth input word stream
//   out_valid / out_ready / out_data  : OWidth output word stream
// master : the side that feeds words in and consumes words out
// slave  : the funnel itself
// ---------------------------------------------------------------------------
interface width_funnel_buffer_if #(
    parameter int IWidth = 32,
    parameter int OWidth = 64
);
    logic              in_valid;
    logic              in_accept;
    logic [IWidth-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OWidth-1:0] out_data;

    modport master (output in_valid, in_data, out_ready,
                    input  in_accept, out_valid, out_data);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_accept, out_valid, out_data);
endinterface

// File: rtl/width_funnel_buffer.sv
// ---------------------------------------------------------------------------
// width_funnel_buffer
// Input FIFO of IWidth words, followed by an integer-ratio IWidth->OWidth
// repacker, followed by an output-beat period counter.
//   clk, rst_n : single rising-edge clock, asynchronous active-low reset
//   bus        : width_funnel_buffer_if.slave (input stream / output stream)
//   count_o    : output transfers so far in the current period
//   done_o     : high in the cycle of the Threshold-th transfer of a period
// Optional feature macro: BEAT_COUNTER_EN. When undefined the counter is not
// built and count_o/done_o are tied to 0; the data path is identical.
// ---------------------------------------------------------------------------
module width_funnel_buffer #(
    parameter  int IWidth    = 32,
    parameter  int OWidth    = 64,
    parameter  int Buffering = 8,
    parameter  int Threshold = 4,
    localparam int CW        = (Threshold > 1) ? $clog2(Threshold) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    width_funnel_buffer_if.slave bus,
    output logic [CW-1:0]        count_o,
    output logic                 done_o
);
    localparam int K   = (OWidth > IWidth) ? OWidth / IWidth : IWidth / OWidth;
    localparam int IXW = (K > 1) ? $clog2(K) : 1;
    localparam int PW  = (Buffering > 1) ? $clog2(Buffering) : 1;
    localparam int OCW = $clog2(Buffering + 1);

    // ---------------- input FIFO ----------------
    logic [IWidth-1:0] mem_q [Buffering];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCW-1:0]    occ_q, occ_d;
    logic              rdy_q;   // holds in_accept low through the first edge after reset
    logic              full, empty, push, pull;
    logic [IWidth-1:0] head;

    assign full          = (occ_q == OCW'(Buffering));
    assign empty         = (occ_q == '0);
    assign bus.in_accept = rdy_q && !full;   // full refuses even while draining
    assign push          = bus.in_valid && bus.in_accept;
    assign head          = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) wr_ptr_d = (wr_ptr_q == PW'(Buffering - 1)) ? '0 : wr_ptr_q + PW'(1);
        if (pull) rd_ptr_d = (rd_ptr_q == PW'(Buffering - 1)) ? '0 : rd_ptr_q + PW'(1);
        if (push && !pull)      occ_d = occ_q + OCW'(1);
        else if (pull && !push) occ_d = occ_q - OCW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            rdy_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            rdy_q    <= 1'b1;
        end
    end

    // storage needs no reset: occupancy alone defines what is valid
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.in_data;
    end

    // ---------------- repacker ----------------
    generate
        if (OWidth > IWidth) begin : g_n2w
            // gather K words, first word in the LSB slice
            logic [OWidth-1:0] data_q, data_d;
            logic [IXW-1:0]    idx_q, idx_d;
            logic              ov_q, ov_d;

            // a stalled full output blocks pulls; on the transfer edge the
            // pulled word starts the next output (no bubble)
            assign pull         = !empty && (!ov_q || bus.out_ready);
            assign bus.out_valid = ov_q;
            assign bus.out_data  = data_q;

            always_comb begin
                data_d = data_q;
                idx_d  = idx_q;
                ov_d   = ov_q;
                if (ov_q && bus.out_ready) ov_d = 1'b0;
                if (pull) begin
                    data_d[idx_q*IWidth +: IWidth] = head;
                    if (idx_q == IXW'(K - 1)) begin
                        idx_d = '0;
                        ov_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IXW'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                    idx_q  <= '0;
                    ov_q   <= 1'b0;
                end else begin
                    data_q <= data_d;
                    idx_q  <= idx_d;
                    ov_q   <= ov_d;
                end
            end
        end else begin : g_w2n
            // one wide word emitted as K chunks, LSB chunk first; K==1 is a
            // plain register stage that can load and emit in the same cycle
            logic [IWidth-1:0] data_q, data_d;
            logic [IXW-1:0]    idx_q, idx_d;
            logic              ov_q, ov_d;
            logic              last;

            assign last          = (idx_q == IXW'(K - 1));
            assign pull          = !empty && (!ov_q || (bus.out_ready && last));
            assign bus.out_valid = ov_q;
            assign bus.out_data  = data_q[idx_q*OWidth +: OWidth];

            always_comb begin
                data_d = data_q;
                idx_d  = idx_q;
                ov_d   = ov_q;
                if (ov_q && bus.out_ready) begin
                    if (last) begin
                        ov_d  = 1'b0;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + IXW'(1);
                    end
                end
                if (pull) begin
                    data_d = head;
                    ov_d   = 1'b1;
                    idx_d  = '0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                    idx_q  <= '0;
                    ov_q   <= 1'b0;
                end else begin
                    data_q <= data_d;
                    idx_q  <= idx_d;
                    ov_q   <= ov_d;
                end
            end
        end
    endgenerate

    // ---------------- output beat counter ----------------
`ifdef BEAT_COUNTER_EN
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fire;

    assign fire    = bus.out_valid && bus.out_ready;
    assign done_o  = fire && (cnt_q == CW'(Threshold - 1));
    assign cnt_d   = done_o ? '0 : (fire ? cnt_q + CW'(1) : cnt_q);
    assign count_o = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign count_o = '0;
    assign done_o  = 1'b0;
`endif
endmodule

// File: tb/tb_width_funnel_buffer.sv
module tb_width_funnel_buffer;
`ifdef BEAT_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int THR = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    width_funnel_buffer_if #(.IWidth(32), .OWidth(64)) ifa ();
    width_funnel_buffer_if #(.IWidth(64), .OWidth(32)) ifb ();
    width_funnel_buffer_if #(.IWidth(32), .OWidth(32)) ifc ();
    logic [1:0] cnt_a, cnt_b;
    logic [0:0] cnt_c;
    logic       done_a, done_b, done_c;

    width_funnel_buffer #(.IWidth(32), .OWidth(64), .Buffering(8), .Threshold(THR)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave), .count_o(cnt_a), .done_o(done_a));
    width_funnel_buffer #(.IWidth(64), .OWidth(32), .Buffering(8), .Threshold(THR)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave), .count_o(cnt_b), .done_o(done_b));
    width_funnel_buffer #(.IWidth(32), .OWidth(32), .Buffering(4), .Threshold(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(ifc.slave), .count_o(cnt_c), .done_o(done_c));

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b0;
        ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; idle_inputs(); repeat (2) tick();
        rst_n = 1'b1; tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle_inputs(); repeat (2) tick();
        checks++; if (ifa.in_accept !== 1'b0) begin failures++; $display("FAIL reset_accept_a got=%b exp=0", ifa.in_accept); end
        checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid_a got=%b exp=0", ifa.out_valid); end
        checks++; if (ifa.out_data !== 64'd0) begin failures++; $display("FAIL reset_data_a got=%h exp=0", ifa.out_data); end
        checks++; if (cnt_a !== 2'd0 || done_a !== 1'b0) begin failures++; $display("FAIL reset_cnt_a got=%0d/%b exp=0/0", cnt_a, done_a); end
        checks++; if (ifb.out_valid !== 1'b0 || ifb.out_data !== 32'd0 || ifb.in_accept !== 1'b0) begin
            failures++; $display("FAIL reset_b got valid=%b data=%h accept=%b exp=0/0/0", ifb.out_valid, ifb.out_data, ifb.in_accept); end
        // a word offered across the release edge must not be taken
        ifc.in_valid = 1'b1; ifc.in_data = 32'hCAFEF00D; ifc.out_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (ifc.in_accept !== 1'b0) begin failures++; $display("FAIL release_accept_c got=%b exp=0", ifc.in_accept); end
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        checks++; if (ifc.out_valid !== 1'b0 || ifc.in_accept !== 1'b1) begin
            failures++; $display("FAIL first_edge_c got valid=%b accept=%b exp=0/1", ifc.out_valid, ifc.in_accept); end
        repeat (3) tick();
        checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL release_word_dropped got valid=%b exp=0", ifc.out_valid); end
    endtask

    task automatic test_narrow_basic();
        do_reset(); ifa.out_ready = 1'b1;
        ifa.in_valid = 1'b1; ifa.in_data = 32'h11111111; tick();
        ifa.in_data = 32'h22222222; tick();
        ifa.in_valid = 1'b0;
        checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL n2w_early got valid=%b exp=0", ifa.out_valid); end
        tick();
        checks++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== 64'h2222222211111111) begin
            failures++; $display("FAIL n2w_beat got valid=%b data=%h exp=1/2222222211111111", ifa.out_valid, ifa.out_data); end
        checks++; if (cnt_a !== 2'd0 || done_a !== 1'b0) begin failures++; $display("FAIL n2w_cnt0 got=%0d/%b exp=0/0", cnt_a, done_a); end
        tick();
        checks++; if (ifa.out_valid !== 1'b0 || cnt_a !== (CNT_EN ? 2'd1 : 2'd0)) begin
            failures++; $display("FAIL n2w_single got valid=%b cnt=%0d exp=0/%0d", ifa.out_valid, cnt_a, CNT_EN); end
    endtask

    task automatic test_wide_basic();
        do_reset(); ifb.out_ready = 1'b1;
        ifb.in_valid = 1'b1; ifb.in_data = 64'hAAAAAAAABBBBBBBB; tick();
        ifb.in_valid = 1'b0;
        checks++; if (ifb.out_valid !== 1'b0) begin failures++; $display("FAIL w2n_early got valid=%b exp=0", ifb.out_valid); end
        tick();
        checks++; if (ifb.out_valid !== 1'b1 || ifb.out_data !== 32'hBBBBBBBB) begin
            failures++; $display("FAIL w2n_chunk0 got valid=%b data=%h exp=1/BBBBBBBB", ifb.out_valid, ifb.out_data); end
        tick();
        checks++; if (ifb.out_valid !== 1'b1 || ifb.out_data !== 32'hAAAAAAAA) begin
            failures++; $display("FAIL w2n_chunk1 got valid=%b data=%h exp=1/AAAAAAAA", ifb.out_valid, ifb.out_data); end
        tick();
        checks++; if (ifb.out_valid !== 1'b0) begin failures++; $display("FAIL w2n_end got valid=%b exp=0", ifb.out_valid); end
    endtask

    task automatic test_full();
        logic [31:0] w [12];
        int n, outs;
        do_reset();
        for (int i = 0; i < 12; i++) w[i] = $urandom();
        n = 0; ifa.out_ready = 1'b0; ifa.in_valid = 1'b1;
        while (n < 12) begin
            ifa.in_data = w[n];
            @(negedge clk);
            if (ifa.in_accept !== 1'b1) break;
            tick(); n++;
        end
        // FIFO depth plus the K=2 words parked in the stalled repacker
        checks++; if (n != 10) begin failures++; $display("FAIL full_depth got=%0d exp=10", n); end
        repeat (3) tick();
        checks++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== {w[1], w[0]}) begin
            failures++; $display("FAIL full_stall_hold got valid=%b data=%h exp=1/%h", ifa.out_valid, ifa.out_data, {w[1], w[0]}); end
        ifa.out_ready = 1'b1; #1;
        checks++; if (ifa.in_accept !== 1'b0) begin failures++; $display("FAIL full_refuse_draining got=%b exp=0", ifa.in_accept); end
        @(negedge clk); ifa.in_valid = 1'b0;
        outs = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (ifa.out_valid && ifa.out_ready) begin
                checks++; if (outs >= 5 || ifa.out_data !== {w[2*outs+1], w[2*outs]}) begin
                    failures++; $display("FAIL full_drain_data idx=%0d got=%h", outs, ifa.out_data); end
                outs++;
            end
            @(negedge clk);
        end
        checks++; if (outs != 5) begin failures++; $display("FAIL full_drain_count got=%0d exp=5", outs); end
    endtask

    task automatic test_backpressure();
        logic [31:0] wa [100];
        logic [63:0] wb [100];
        logic [63:0] qa [$];
        logic [31:0] qb [$];
        logic [63:0] held_a;
        logic [31:0] held_b;
        bit hv_a, hv_b;
        int ga, gb;
        do_reset();
        ga = 0; gb = 0; hv_a = 0; hv_b = 0;
        for (int i = 0; i < 100; i++) begin wa[i] = $urandom(); wb[i] = {$urandom(), $urandom()}; end
        for (int i = 0; i < 50; i++) qa.push_back({wa[2*i+1], wa[2*i]});
        for (int i = 0; i < 100; i++) begin qb.push_back(wb[i][31:0]); qb.push_back(wb[i][63:32]); end
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    ifa.in_valid = 1'b0;
                    while ($urandom_range(3) == 0) tick();
                    ifa.in_valid = 1'b1; ifa.in_data = wa[i];
                    for (int t = 0; t < 200; t++) begin @(negedge clk); if (ifa.in_accept) break; end
                    tick();
                end
                ifa.in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 100; i++) begin
                    ifb.in_valid = 1'b0;
                    while ($urandom_range(3) == 0) tick();
                    ifb.in_valid = 1'b1; ifb.in_data = wb[i];
                    for (int t = 0; t < 400; t++) begin @(negedge clk); if (ifb.in_accept) break; end
                    tick();
                end
                ifb.in_valid = 1'b0;
            end
            begin
                for (int t = 0; t < 4000 && ga < 50; t++) begin
                    ifa.out_ready = ($urandom_range(1) == 1);
                    @(negedge clk);
                    if (hv_a) begin
                        checks++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== held_a) begin
                            failures++; $display("FAIL bp_stall_a got valid=%b data=%h exp=1/%h", ifa.out_valid, ifa.out_data, held_a); end
                    end
                    hv_a = 0;
                    if (ifa.out_valid && ifa.out_ready) begin
                        checks++; if (ifa.out_data !== qa[ga] || cnt_a !== (CNT_EN ? 2'(ga % THR) : 2'd0) || done_a !== (CNT_EN && (ga % THR == THR - 1))) begin
                            failures++; $display("FAIL bp_data_a idx=%0d got=%h/%0d/%b exp=%h", ga, ifa.out_data, cnt_a, done_a, qa[ga]); end
                        ga++;
                    end else if (ifa.out_valid) begin
                        held_a = ifa.out_data; hv_a = 1;
                    end
                    tick();
                end
                ifa.out_ready = 1'b0;
            end
            begin
                for (int t = 0; t < 4000 && gb < 200; t++) begin
                    ifb.out_ready = ($urandom_range(1) == 1);
                    @(negedge clk);
                    if (hv_b) begin
                        checks++; if (ifb.out_valid !== 1'b1 || ifb.out_data !== held_b) begin
                            failures++; $display("FAIL bp_stall_b got valid=%b data=%h exp=1/%h", ifb.out_valid, ifb.out_data, held_b); end
                    end
                    hv_b = 0;
                    if (ifb.out_valid && ifb.out_ready) begin
                        checks++; if (ifb.out_data !== qb[gb] || cnt_b !== (CNT_EN ? 2'(gb % THR) : 2'd0) || done_b !== (CNT_EN && (gb % THR == THR - 1))) begin
                            failures++; $display("FAIL bp_data_b idx=%0d got=%h/%0d/%b exp=%h", gb, ifb.out_data, cnt_b, done_b, qb[gb]); end
                        gb++;
                    end else if (ifb.out_valid) begin
                        held_b = ifb.out_data; hv_b = 1;
                    end
                    tick();
                end
                ifb.out_ready = 1'b0;
            end
        join
        checks++; if (ga != 50) begin failures++; $display("FAIL bp_count_a got=%0d exp=50", ga); end
        checks++; if (gb != 200) begin failures++; $display("FAIL bp_count_b got=%0d exp=200", gb); end
    endtask

    task automatic test_counter();
        int n;
        do_reset(); ifb.out_ready = 1'b1; n = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    ifb.in_valid = 1'b1; ifb.in_data = {$urandom(), $urandom()};
                    for (int t = 0; t < 50; t++) begin @(negedge clk); if (ifb.in_accept) break; end
                    tick();
                end
                ifb.in_valid = 1'b0;
            end
            begin
                for (int t = 0; t < 200 && n < 9; t++) begin
                    @(negedge clk);
                    if (ifb.out_valid && ifb.out_ready) begin
                        n++;
                        checks++; if (done_b !== (CNT_EN && (n == 4 || n == 8))) begin
                            failures++; $display("FAIL cnt_done transfer=%0d got=%b exp=%b", n, done_b, CNT_EN && (n == 4 || n == 8)); end
                    end
                    tick();
                end
                ifb.out_ready = 1'b0; #1;
            end
        join
        checks++; if (n != 9) begin failures++; $display("FAIL cnt_transfers got=%0d exp=9", n); end
        checks++; if (cnt_b !== (CNT_EN ? 2'd1 : 2'd0) || done_b !== 1'b0) begin
            failures++; $display("FAIL cnt_after9 got=%0d/%b exp=%0d/0", cnt_b, done_b, CNT_EN); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wc [9];
        int t0;
        do_reset(); ifc.out_ready = 1'b1; t0 = 0;
        for (int i = 0; i < 9; i++) wc[i] = $urandom();
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    ifc.in_valid = 1'b1; ifc.in_data = wc[i];
                    @(negedge clk);
                    checks++; if (ifc.in_accept !== 1'b1) begin failures++; $display("FAIL b2b_accept idx=%0d got=%b exp=1", i, ifc.in_accept); end
                    tick();
                end
                ifc.in_valid = 1'b0;
            end
            begin
                while (ifc.out_valid !== 1'b1 && t0 < 20) begin @(negedge clk); t0++; end
                checks++; if (t0 != 3) begin failures++; $display("FAIL b2b_latency got=%0d exp=3", t0); end
                for (int i = 0; i < 9; i++) begin
                    checks++; if (ifc.out_valid !== 1'b1 || ifc.out_data !== wc[i] || done_c !== CNT_EN || cnt_c !== 1'b0) begin
                        failures++; $display("FAIL b2b_beat idx=%0d got=%b/%h/%b/%0d exp=1/%h/%b/0", i, ifc.out_valid, ifc.out_data, done_c, cnt_c, wc[i], CNT_EN); end
                    @(negedge clk);
                end
                checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_tail got valid=%b exp=0", ifc.out_valid); end
            end
        join
    endtask

    task automatic test_reset_mid();
        int t0, extra;
        do_reset(); ifa.out_ready = 1'b1;
        ifa.in_valid = 1'b1; ifa.in_data = 32'h00000001; tick();
        ifa.in_data = 32'h00000002; tick();
        ifa.in_data = 32'h0BAD0BAD; tick();
        ifa.in_valid = 1'b0;
        repeat (2) tick();
        checks++; if (cnt_a !== (CNT_EN ? 2'd1 : 2'd0)) begin failures++; $display("FAIL rm_pre_count got=%0d exp=%0d", cnt_a, CNT_EN); end
        rst_n = 1'b0; #1;
        checks++; if (ifa.out_valid !== 1'b0 || cnt_a !== 2'd0 || ifa.out_data !== 64'd0) begin
            failures++; $display("FAIL rm_cleared got valid=%b cnt=%0d data=%h exp=0/0/0", ifa.out_valid, cnt_a, ifa.out_data); end
        @(negedge clk); rst_n = 1'b1;
        tick();
        ifa.in_valid = 1'b1; ifa.in_data = 32'h5555AAAA; tick();
        ifa.in_data = 32'h3333CCCC; tick();
        ifa.in_valid = 1'b0;
        t0 = 0;
        while (ifa.out_valid !== 1'b1 && t0 < 10) begin @(negedge clk); t0++; end
        checks++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== 64'h3333CCCC5555AAAA) begin
            failures++; $display("FAIL rm_new_data got valid=%b data=%h exp=1/3333CCCC5555AAAA", ifa.out_valid, ifa.out_data); end
        extra = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (ifa.out_valid) extra++;
            @(negedge clk);
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL rm_no_partial got=%0d exp=0", extra); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_narrow_basic();
        test_wide_basic();
        test_full();
        test_backpressure();
        test_counter();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
